// File: rtl/mul_pkg.sv
// mul_pkg: shared flag, rounding-mode and format definitions for the FP multiplier pack stage.
package mul_pkg;
  localparam int SIGN_W = 1;
  localparam int EXPO_W_DEF = 8;
  localparam int MANT_W_DEF = 23;
  localparam int EMAX = 2 ** EXPO_W_DEF - 1;
  localparam int RES_W = SIGN_W + EXPO_W_DEF + MANT_W_DEF;
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
  typedef enum logic [1:0] {
    RND_RTZ = 2'b00,
    RND_RDN = 2'b01,
    RND_RUP = 2'b10,
    RND_RNE = 2'b11
  } rnd_t;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;
  function automatic int res_w(input int expo_w, input int mant_w);
    return SIGN_W + expo_w + mant_w;
  endfunction
endpackage

// File: rtl/mul_pack_cls.sv
// mul_pack_cls: classifies the rounded result and packs it into IEEE-754 with its exception flags.
module mul_pack_cls
  import mul_pkg::*;
#(
  parameter int EXPO_W = EXPO_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic                       sign_1,
  input  logic [EXPO_W+1:0]          expo_3,
  input  logic [MANT_W-1:0]          mant_3,
  input  logic                       inexact_rnd,
  input  logic [1:0]                 rnd,
  input  logic                       is_nan,
  input  logic                       is_inv,
  input  logic                       is_inf,
  input  logic                       is_zero,
  output logic [res_w(EXPO_W, MANT_W)-1:0] res,
  output fp_flags_t                  flags
);
  logic neg, ovf, away;
  // Bit EXPO_W+1 is the sign of the exponent; a non-negative value at or above all-ones overflows.
  assign neg  = expo_3[EXPO_W+1];
  assign ovf  = !neg && (expo_3 >= {2'b00, {EXPO_W{1'b1}}});
  assign away = (rnd == RND_RUP && !sign_1) || (rnd == RND_RDN && sign_1);
  always_comb begin
    flags = '0;
    res = {sign_1, expo_3[EXPO_W-1:0], mant_3};
    if (is_nan || is_inv) begin
      res = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      flags.nv = is_inv;
    end else if (is_inf) begin
      res = {sign_1, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (is_zero) begin
      res = {sign_1, {(EXPO_W+MANT_W){1'b0}}};
    end else if (ovf) begin
      flags.of = 1'b1;
      flags.nx = 1'b1;
      res = (away || rnd == RND_RNE) ? {sign_1, {EXPO_W{1'b1}}, {MANT_W{1'b0}}}
                                     : {sign_1, {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
    end else if (neg) begin
      flags.uf = 1'b1;
      flags.nx = 1'b1;
      res = away ? {sign_1, {(EXPO_W+MANT_W-1){1'b0}}, 1'b1} : {sign_1, {(EXPO_W+MANT_W){1'b0}}};
    end else if (expo_3 == '0) begin
      flags.uf = inexact_rnd;
      flags.nx = inexact_rnd;
    end else begin
      flags.nx = inexact_rnd;
    end
  end
endmodule

// File: rtl/mul_pack.sv
// mul_pack: output register stage of the FP multiplier with valid/ready handshake and sticky fflags.
module mul_pack
  import mul_pkg::*;
#(
  parameter int SIGN_W_P = SIGN_W,
  parameter int EXPO_W = EXPO_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SIGN_W_P-1:0]               sign_1,
  input  logic [EXPO_W+1:0]                 expo_3,
  input  logic [MANT_W-1:0]                 mant_3,
  input  logic                              inexact_rnd,
  input  logic [1:0]                        rnd,
  input  logic                              is_nan,
  input  logic                              is_inv,
  input  logic                              is_inf,
  input  logic                              is_zero,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SIGN_W_P+EXPO_W+MANT_W-1:0] res,
  output logic [4:0]                        flags,
  output logic [4:0]                        fflags,
  input  logic                              fflags_clr
);
  logic [SIGN_W_P+EXPO_W+MANT_W-1:0] nres;
  fp_flags_t nflags;
  logic load, done;
  assign in_ready = !out_valid || out_ready;
  assign load = in_valid && in_ready;
  assign done = out_valid && out_ready;
  mul_pack_cls #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls (
    .sign_1(sign_1[0]), .expo_3(expo_3), .mant_3(mant_3), .inexact_rnd(inexact_rnd), .rnd(rnd),
    .is_nan(is_nan), .is_inv(is_inv), .is_inf(is_inf), .is_zero(is_zero),
    .res(nres), .flags(nflags)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res <= '0;
      flags <= '0;
      fflags <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        res <= nres;
        flags <= nflags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      fflags <= (fflags_clr ? 5'd0 : fflags) | (done ? flags : 5'd0);
    end
  end
endmodule
